// File: rtl/spi_byte_out.sv
// rtl/spi_byte_out.sv - FIFO-buffered SPI mode 0 byte transmitter with MISO capture
module spi_byte_out #(
  parameter int DIV     = 2,
  parameter int CS_GAP  = 1,
  parameter int FIFO_AW = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       LOAD,
  input  logic [7:0] BYTEIN,
  input  logic       MISO,
  output logic       SCLK,
  output logic       MOSI,
  output logic       CS_N,
  output logic       BUSY,
  output logic       FULL,
  output logic       OVERRUN,
  output logic [7:0] RX_BYTE,
  output logic       RX_VALID
);

  localparam int               DEPTH    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_C  = (FIFO_AW + 1)'(DEPTH);
  localparam logic [7:0]       DIV_LAST = 8'(DIV - 1);
  localparam logic [7:0]       GAP_LAST = 8'(CS_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wptr_q, rptr_q;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               full_q, empty_q, overrun_q;
  logic               push, pop;

  // Frame engine state
  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d;
  logic       sclk_q, sclk_d;
  logic       mosi_q, mosi_d;
  logic       cs_n_q, cs_n_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       rx_valid_q, rx_valid_d;

  // A pop frees a slot on the same edge, so a LOAD into a full FIFO is still taken then
  assign pop  = (state_q == S_IDLE) && !empty_q;
  assign push = LOAD && (!full_q || pop);

  // Occupancy after this cycle's push/pop
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  // Byte storage; contents need no reset since the pointers define validity
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wptr_q] <= BYTEIN;
    end
  end

  // Pointers, registered flags and the sticky drop indicator
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      overrun_q <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == DEPTH_C);
      empty_q <= (count_d == '0);
      if (LOAD && full_q && !pop) overrun_q <= 1'b1;
    end
  end

  // Frame sequencing: one CS frame per byte, DIV clocks per SCLK phase
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    rx_byte_d  = rx_byte_q;
    rx_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        mosi_d = 1'b0;
        if (!empty_q) begin
          tx_d    = mem_q[rptr_q];
          mosi_d  = mem_q[rptr_q][7];
          cs_n_d  = 1'b0;
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          sclk_d  = 1'b1;
          rx_d    = {rx_q[6:0], MISO};
          state_d = S_SHIFT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (sclk_q) begin
            sclk_d = 1'b0;
            if (bit_q == 3'd7) begin
              state_d = S_HOLD;
            end else begin
              bit_d  = bit_q + 3'd1;
              tx_d   = {tx_q[6:0], 1'b0};
              mosi_d = tx_q[6];
            end
          end else begin
            sclk_d = 1'b1;
            rx_d   = {rx_q[6:0], MISO};
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_HOLD: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d      = '0;
          cs_n_d     = 1'b1;
          rx_byte_d  = rx_q;
          rx_valid_d = 1'b1;
          if (CS_GAP == 0) begin
            state_d = S_IDLE;
            mosi_d  = 1'b0;
          end else begin
            state_d = S_GAP;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          mosi_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        sclk_d  = 1'b0;
        cs_n_d  = 1'b1;
        mosi_d  = 1'b0;
      end
    endcase
  end

  // Frame engine registers; reset aborts any frame in flight
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      rx_byte_q  <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign SCLK     = sclk_q;
  assign MOSI     = mosi_q;
  assign CS_N     = cs_n_q;
  assign BUSY     = !((state_q == S_IDLE) && empty_q);
  assign FULL     = full_q;
  assign OVERRUN  = overrun_q;
  assign RX_BYTE  = rx_byte_q;
  assign RX_VALID = rx_valid_q;

endmodule

// File: tb/tb_spi_byte_out.sv
// tb/tb_spi_byte_out.sv - directed bench for spi_byte_out frames, FIFO and reset
module tb_spi_byte_out;

  logic       CLK   = 1'b0;
  logic       RESET = 1'b1;
  logic       load  = 1'b0;
  logic [7:0] bytein = 8'h00;
  logic       miso  = 1'b0;
  logic       sclk, mosi, cs_n, busy, full, overrun, rx_valid;
  logic [7:0] rx_byte;

  logic       load1  = 1'b0;
  logic [7:0] bytein1 = 8'h00;
  logic       miso1;
  logic       sclk1, mosi1, cs_n1, busy1, full1, overrun1, rx_valid1;
  logic [7:0] rx_byte1;

  assign miso1 = 1'b0;

  always #5 CLK = ~CLK;

  spi_byte_out #(.DIV(2), .CS_GAP(1), .FIFO_AW(2)) dut (
    .CLK(CLK), .RESET(RESET), .LOAD(load), .BYTEIN(bytein), .MISO(miso),
    .SCLK(sclk), .MOSI(mosi), .CS_N(cs_n), .BUSY(busy), .FULL(full),
    .OVERRUN(overrun), .RX_BYTE(rx_byte), .RX_VALID(rx_valid)
  );

  spi_byte_out #(.DIV(1), .CS_GAP(1), .FIFO_AW(2)) dut1 (
    .CLK(CLK), .RESET(RESET), .LOAD(load1), .BYTEIN(bytein1), .MISO(miso1),
    .SCLK(sclk1), .MOSI(mosi1), .CS_N(cs_n1), .BUSY(busy1), .FULL(full1),
    .OVERRUN(overrun1), .RX_BYTE(rx_byte1), .RX_VALID(rx_valid1)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic full_seen = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Frame monitor and mode-0 slave for dut (DIV=2)
  localparam int D0 = 2;
  logic       cs_prev = 1'b1, sclk_prev = 1'b0, have_prev = 1'b0, bad = 1'b0;
  logic [7:0] slave_byte = 8'h00;
  logic [7:0] cap = 8'h00;
  int t_fall = 0, t_rise_cs = 0, nrise = 0, nfall = 0, sbit = 7;
  int frame_cnt = 0, rxv_cnt = 0;
  logic [7:0] tx_log [64];
  logic [7:0] rx_log [64];
  logic       ok_log [64];
  logic       rxv_log [64];
  int         csl_log [64];
  int         gap_log [64];
  int         fall_log [64];

  always @(negedge CLK) begin
    if (!RESET) begin
      cs_prev   = 1'b1;
      sclk_prev = 1'b0;
      miso      = 1'b0;
    end else begin
      if (rx_valid) rxv_cnt++;
      if (cs_prev && !cs_n) begin
        gap_log[frame_cnt] = have_prev ? (cyc - t_rise_cs) : 0;
        t_fall = cyc;
        nrise  = 0;
        nfall  = 0;
        cap    = 8'h00;
        bad    = 1'b0;
        sbit   = 7;
        miso   = slave_byte[7];
      end
      if (!cs_n && !sclk_prev && sclk) begin
        if (cyc - t_fall != (2 * nrise + 1) * D0) bad = 1'b1;
        cap = {cap[6:0], mosi};
        nrise++;
      end
      if (!cs_n && sclk_prev && !sclk) begin
        if (cyc - t_fall != (2 * nfall + 2) * D0) bad = 1'b1;
        nfall++;
        if (sbit > 0) sbit--;
        miso = slave_byte[sbit];
      end
      if (!cs_prev && cs_n) begin
        if (nrise != 8 || nfall != 8) bad = 1'b1;
        tx_log[frame_cnt]   = cap;
        rx_log[frame_cnt]   = rx_byte;
        rxv_log[frame_cnt]  = rx_valid;
        ok_log[frame_cnt]   = !bad;
        csl_log[frame_cnt]  = cyc - t_fall;
        fall_log[frame_cnt] = t_fall;
        t_rise_cs = cyc;
        have_prev = 1'b1;
        frame_cnt++;
      end
      cs_prev   = cs_n;
      sclk_prev = sclk;
    end
  end

  // Frame monitor for dut1 (DIV=1)
  logic       cs1_prev = 1'b1, sclk1_prev = 1'b0;
  logic [7:0] cap1 = 8'h00;
  int t1_fall = 0, t1_low = 0, n1rise = 0, t1_r0 = 0, t1_r1 = 0, frames1 = 0;

  always @(negedge CLK) begin
    if (!RESET) begin
      cs1_prev   = 1'b1;
      sclk1_prev = 1'b0;
    end else begin
      if (cs1_prev && !cs_n1) begin
        t1_fall = cyc;
        n1rise  = 0;
        cap1    = 8'h00;
      end
      if (!cs_n1 && !sclk1_prev && sclk1) begin
        if (n1rise == 0) t1_r0 = cyc;
        if (n1rise == 1) t1_r1 = cyc;
        cap1 = {cap1[6:0], mosi1};
        n1rise++;
      end
      if (!cs1_prev && cs_n1) begin
        t1_low = cyc - t1_fall;
        frames1++;
      end
      cs1_prev   = cs_n1;
      sclk1_prev = sclk1;
    end
  end

  typedef struct {
    logic [7:0] din;
    logic [7:0] sdat;
    logic [7:0] exp_mosi;
    logic [7:0] exp_rx;
    int         exp_low;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    #1;
    if (full) full_seen = 1'b1;
  endtask

  task automatic wait_frames(input int target, input string name);
    int n = 0;
    while (frame_cnt < target && n < 400) begin
      tick();
      n++;
    end
    if (frame_cnt < target) check(name, frame_cnt, target);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 2000) begin
      tick();
      n++;
    end
    if (busy) check(name, busy, 0);
  endtask

  task automatic do_reset();
    tick();
    RESET = 1'b0;
    repeat (2) tick();
    RESET = 1'b1;
    tick();
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int f0, r0, tl;
    slave_byte = v.sdat;
    f0 = frame_cnt;
    r0 = rxv_cnt;
    tick();
    load   = 1'b1;
    bytein = v.din;
    tick();
    load = 1'b0;
    tl   = cyc;
    check({name, " busy_after_load"}, busy, 1);
    wait_frames(f0 + 1, {name, " frame_timeout"});
    check({name, " cs_latency"}, fall_log[f0] - tl, 1);
    check({name, " sclk_timing"}, ok_log[f0], 1);
    check({name, " mosi_byte"}, tx_log[f0], v.exp_mosi);
    check({name, " cs_low_cycles"}, csl_log[f0], v.exp_low);
    check({name, " rx_valid_at_cs_rise"}, rxv_log[f0], 1);
    check({name, " rx_byte"}, rx_log[f0], v.exp_rx);
    repeat (4) tick();
    check({name, " rx_valid_pulses"}, rxv_cnt - r0, 1);
    check({name, " busy_idle"}, busy, 0);
    check({name, " mosi_idle"}, mosi, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, r0, tl, n;
    vecs[0] = '{8'hA5, 8'h3C, 8'hA5, 8'h3C, 34};
    vecs[1] = '{8'h00, 8'hFF, 8'h00, 8'hFF, 34};
    vecs[2] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 34};
    vecs[3] = '{8'h5A, 8'h81, 8'h5A, 8'h81, 34};
    vecs[4] = '{8'hC3, 8'hE7, 8'hC3, 8'hE7, 34};

    #1 RESET = 1'b0;
    repeat (3) tick();
    check("reset sclk", sclk, 0);
    check("reset mosi", mosi, 0);
    check("reset cs_n", cs_n, 1);
    check("reset busy", busy, 0);
    check("reset full", full, 0);
    check("reset overrun", overrun, 0);
    check("reset rx_byte", rx_byte, 8'h00);
    check("reset rx_valid", rx_valid, 0);
    RESET = 1'b1;
    tick();

    // Isolated frames
    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Four back-to-back loads: first pops at once so FULL never asserts
    do_reset();
    slave_byte = 8'h96;
    f0 = frame_cnt;
    full_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      load   = 1'b1;
      bytein = 8'(i + 1);
    end
    tick();
    load = 1'b0;
    wait_idle("burst4 idle_timeout");
    check("burst4 frames_at_busy_drop", frame_cnt - f0, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("burst4 mosi%0d", i), tx_log[f0 + i], 8'(i + 1));
      check($sformatf("burst4 rx%0d", i), rx_log[f0 + i], 8'h96);
      check($sformatf("burst4 timing%0d", i), ok_log[f0 + i], 1);
    end
    for (int i = 1; i < 4; i++) begin
      check($sformatf("burst4 gap%0d", i), gap_log[f0 + i], 2);
    end
    check("burst4 full_never", full_seen, 0);
    check("burst4 overrun", overrun, 0);

    // Fill the FIFO, then drop two loads mid-shift
    do_reset();
    f0 = frame_cnt;
    for (int i = 0; i < 5; i++) begin
      tick();
      load   = 1'b1;
      bytein = 8'(8'h11 * (i + 1));
    end
    tick();
    load = 1'b0;
    check("drop full_set", full, 1);
    check("drop overrun_before", overrun, 0);
    repeat (4) tick();
    check("drop mid_frame", cs_n, 0);
    load   = 1'b1;
    bytein = 8'hEE;
    tick();
    load = 1'b0;
    check("drop overrun_set", overrun, 1);
    tick();
    load   = 1'b1;
    bytein = 8'hDD;
    tick();
    load = 1'b0;
    check("drop full_still", full, 1);
    wait_idle("drop idle_timeout");
    check("drop frame_count", frame_cnt - f0, 5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("drop mosi%0d", i), tx_log[f0 + i], 8'(8'h11 * (i + 1)));
    end
    check("drop overrun_sticky", overrun, 1);

    // Async reset after the third SCLK rise
    do_reset();
    slave_byte = 8'h3C;
    r0 = rxv_cnt;
    tick();
    load   = 1'b1;
    bytein = 8'h5A;
    tick();
    load = 1'b0;
    n = 0;
    while (!(!cs_n && nrise == 3) && n < 100) begin
      tick();
      n++;
    end
    check("rst sclk_high_before", sclk, 1);
    #1 RESET = 1'b0;
    #1;
    check("rst sclk", sclk, 0);
    check("rst cs_n", cs_n, 1);
    check("rst busy", busy, 0);
    check("rst rx_valid", rx_valid, 0);
    check("rst mosi", mosi, 0);
    repeat (3) tick();
    RESET = 1'b1;
    tick();
    check("rst no_rx_valid", rxv_cnt - r0, 0);
    run_vec('{8'hFF, 8'hA5, 8'hFF, 8'hA5, 34}, "post_rst");

    // DIV=1 instance
    f0 = frames1;
    tick();
    load1   = 1'b1;
    bytein1 = 8'h80;
    tick();
    load1 = 1'b0;
    tl    = cyc;
    n = 0;
    while (frames1 == f0 && n < 100) begin
      tick();
      n++;
    end
    check("div1 frame_done", frames1 - f0, 1);
    check("div1 cs_latency", t1_fall - tl, 1);
    check("div1 cs_low", t1_low, 17);
    check("div1 sclk_period", t1_r1 - t1_r0, 2);
    check("div1 rises", n1rise, 8);
    check("div1 mosi", cap1, 8'h80);

    // Load accepted into a full FIFO on the pop edge
    do_reset();
    f0 = frame_cnt;
    for (int i = 0; i < 5; i++) begin
      tick();
      load   = 1'b1;
      bytein = 8'(8'hA1 + i);
    end
    tick();
    load = 1'b0;
    check("popwr full_set", full, 1);
    wait_frames(f0 + 1, "popwr first_frame_timeout");
    tick();
    check("popwr in_gap", cs_n, 1);
    load   = 1'b1;
    bytein = 8'hA6;
    tick();
    load = 1'b0;
    check("popwr pop_edge", cs_n, 0);
    check("popwr full_kept", full, 1);
    check("popwr overrun", overrun, 0);
    wait_idle("popwr idle_timeout");
    check("popwr frame_count", frame_cnt - f0, 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("popwr mosi%0d", i), tx_log[f0 + i], 8'(8'hA1 + i));
    end
    check("popwr overrun_end", overrun, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
